// File: rtl/alu_arbiter_pkg.sv
// Shared types for the two-requester ALU arbiter: operation codes, FSM state
// encoding and the arbitration helper.
package alu_arbiter_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd5
    } alu_op_e;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_RESP = 1'b1;

    // Lone requester always wins; on contention the preferred index wins.
    function automatic logic arb_winner(input logic [1:0] valid, input logic prefer);
        logic w;
        case (valid)
            2'b01:   w = 1'b0;
            2'b10:   w = 1'b1;
            2'b11:   w = prefer;
            default: w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by the arbiter: add/sub/and/or/unsigned-slt plus
// operand-equality and zero-result flags. Unused codes yield zero.
module alu
    import alu_arbiter_pkg::*;
#(
    parameter int INPUT_WIDTH   = 32,
    parameter int CONTROL_WIDTH = 3
) (
    input  logic [INPUT_WIDTH-1:0]   op1,
    input  logic [INPUT_WIDTH-1:0]   op2,
    input  logic [CONTROL_WIDTH-1:0] ctrl,
    output logic [INPUT_WIDTH-1:0]   result,
    output logic                     eq,
    output logic                     zero
);

    always_comb begin
        result = '0;
        case (ctrl)
            CONTROL_WIDTH'(ALU_ADD): result = op1 + op2;
            CONTROL_WIDTH'(ALU_SUB): result = op1 - op2;
            CONTROL_WIDTH'(ALU_AND): result = op1 & op2;
            CONTROL_WIDTH'(ALU_OR):  result = op1 | op2;
            CONTROL_WIDTH'(ALU_SLT): result = {{(INPUT_WIDTH-1){1'b0}}, (op1 < op2)};
            default:                 result = '0;
        endcase
    end

    assign eq   = (op1 == op2);
    assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one ALU: IDLE/RESP FSM, round-robin grant
// and hold registers. Define ALU_ARBITER_FIXED_PRIO_EN for fixed requester-0 priority.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int INPUT_WIDTH   = 32,
    parameter int CONTROL_WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [2*INPUT_WIDTH-1:0]   req_op1,
    input  logic [2*INPUT_WIDTH-1:0]   req_op2,
    input  logic [2*CONTROL_WIDTH-1:0] req_ctrl,
    output logic [1:0]                 rsp_valid,
    input  logic [1:0]                 rsp_ready,
    output logic [INPUT_WIDTH-1:0]     rsp_data,
    output logic                       rsp_eq,
    output logic                       rsp_zero,
    output logic                       busy
);

    state_t                   state_p1;
    logic                     grant_p1;
    logic [INPUT_WIDTH-1:0]   op1_p1;
    logic [INPUT_WIDTH-1:0]   op2_p1;
    logic [CONTROL_WIDTH-1:0] ctrl_p1;

    logic                     win_pref;
    logic                     winner;
    logic                     rsp_fire;
    logic                     can_accept;
    logic                     accept;
    logic [INPUT_WIDTH-1:0]   sel_op1;
    logic [INPUT_WIDTH-1:0]   sel_op2;
    logic [CONTROL_WIDTH-1:0] sel_ctrl;

`ifdef ALU_ARBITER_FIXED_PRIO_EN
    assign win_pref = 1'b0;
`else
    logic last_grant_p1;

    assign win_pref = ~last_grant_p1;

    // Reset to requester 1 so requester 0 wins the first contended cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_p1 <= 1'b1;
        end else if (accept) begin
            last_grant_p1 <= winner;
        end
    end
`endif

    assign winner     = arb_winner(req_valid, win_pref);
    assign rsp_fire   = (state_p1 == ST_RESP) && rsp_ready[grant_p1];
    assign can_accept = (state_p1 == ST_IDLE) || rsp_fire;

    // rst_n gates ready so nothing is offered while reset is asserted.
    assign req_ready = (rst_n && can_accept && req_valid[winner]) ? (2'b01 << winner) : 2'b00;
    assign accept    = |req_ready;

    assign sel_op1  = winner ? req_op1[INPUT_WIDTH +: INPUT_WIDTH]     : req_op1[0 +: INPUT_WIDTH];
    assign sel_op2  = winner ? req_op2[INPUT_WIDTH +: INPUT_WIDTH]     : req_op2[0 +: INPUT_WIDTH];
    assign sel_ctrl = winner ? req_ctrl[CONTROL_WIDTH +: CONTROL_WIDTH] : req_ctrl[0 +: CONTROL_WIDTH];

    // Stage p1: accepted request held until its response handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1 <= ST_IDLE;
            grant_p1 <= 1'b0;
            op1_p1   <= '0;
            op2_p1   <= '0;
            ctrl_p1  <= '0;
        end else if (accept) begin
            state_p1 <= ST_RESP;
            grant_p1 <= winner;
            op1_p1   <= sel_op1;
            op2_p1   <= sel_op2;
            ctrl_p1  <= sel_ctrl;
        end else if (rsp_fire) begin
            state_p1 <= ST_IDLE;
        end
    end

    assign busy      = (state_p1 == ST_RESP);
    assign rsp_valid = busy ? (2'b01 << grant_p1) : 2'b00;

    alu #(
        .INPUT_WIDTH  (INPUT_WIDTH),
        .CONTROL_WIDTH(CONTROL_WIDTH)
    ) u_alu (
        .op1   (op1_p1),
        .op2   (op2_p1),
        .ctrl  (ctrl_p1),
        .result(rsp_data),
        .eq    (rsp_eq),
        .zero  (rsp_zero)
    );

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios against fixed
// values plus randomized traffic against a transaction-level reference model.
module tb_alu_arbiter;

`ifdef ALU_ARBITER_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [63:0] req_op1 = '0;
    logic [63:0] req_op2 = '0;
    logic [5:0]  req_ctrl = '0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = '0;
    logic [31:0] rsp_data;
    logic        rsp_eq;
    logic        rsp_zero;
    logic        busy;

    int compared = 0;
    int mismatched = 0;

    alu_arbiter #(.INPUT_WIDTH(32), .CONTROL_WIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op1(req_op1), .req_op2(req_op2), .req_ctrl(req_ctrl),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_eq(rsp_eq), .rsp_zero(rsp_zero),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: one held transaction plus the last served requester.
    bit          m_held;
    int          m_grant;
    int          m_last;
    logic [31:0] m_op1, m_op2;
    logic [2:0]  m_ctrl;
    logic [1:0]  e_ready, e_rvalid;
    logic [31:0] e_data;
    logic        e_eq, e_zero, e_fire;
    int          e_winner;

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] c);
        case (c)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd5: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_held = 0; m_grant = 0; m_last = 1;
        m_op1 = '0; m_op2 = '0; m_ctrl = '0;
    endtask

    task automatic model_eval();
        e_rvalid = m_held ? (2'b01 << m_grant) : 2'b00;
        e_fire = m_held && rsp_ready[m_grant];
        if (req_valid == 2'b11) e_winner = FIXED ? 0 : 1 - m_last;
        else e_winner = req_valid[0] ? 0 : 1;
        e_ready = ((!m_held || e_fire) && req_valid != 2'b00) ? (2'b01 << e_winner) : 2'b00;
        e_data = ref_alu(m_op1, m_op2, m_ctrl);
        e_eq = (m_op1 == m_op2);
        e_zero = (e_data == 32'd0);
    endtask

    task automatic edge_commit();
        @(posedge clk);
        if (e_ready != 2'b00) begin
            m_held = 1; m_grant = e_winner; m_last = e_winner;
            m_op1 = req_op1[e_winner*32 +: 32];
            m_op2 = req_op2[e_winner*32 +: 32];
            m_ctrl = req_ctrl[e_winner*3 +: 3];
        end else if (e_fire) begin
            m_held = 0;
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] b0,
                         input logic [2:0] c0, input logic [31:0] a1, input logic [31:0] b1,
                         input logic [2:0] c1, input logic [1:0] rr);
        @(negedge clk);
        req_valid = v; req_op1 = {a1, a0}; req_op2 = {b1, b0}; req_ctrl = {c1, c0};
        rsp_ready = rr;
        #1;
        model_eval();
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 0; req_valid = '0; rsp_ready = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 0; req_valid = 2'b11; rsp_ready = 2'b11;
        model_reset();
        #1;
        compared++;
        if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_ctrl: req_ready=%b rsp_valid=%b busy=%b, required 00/00/0",
                     req_ready, rsp_valid, busy);
        end
        compared++;
        if (rsp_data !== 32'd0 || rsp_zero !== 1'b1 || rsp_eq !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_hold: data=%h zero=%b eq=%b, required 0/1/1", rsp_data, rsp_zero, rsp_eq);
        end
        @(negedge clk);
        req_valid = '0; rsp_ready = '0;
        rst_n = 1;
    endtask

    task automatic test_single_op();
        reset_dut();
        drive(2'b01, 32'd5, 32'd7, 3'd1, 32'd0, 32'd0, 3'd0, 2'b00);
        compared++;
        if (req_ready !== 2'b01 || rsp_valid !== 2'b00) begin
            mismatched++;
            $display("FAIL single_accept: req_ready=%b rsp_valid=%b, required 01/00", req_ready, rsp_valid);
        end
        edge_commit();
        drive(2'b00, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0, 3'd0, 2'b00);
        compared++;
        if (rsp_valid !== 2'b01 || rsp_data !== 32'hFFFF_FFFE || rsp_eq !== 1'b0 ||
            rsp_zero !== 1'b0 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL single_rsp: valid=%b data=%h eq=%b zero=%b busy=%b, required 01/fffffffe/0/0/1",
                     rsp_valid, rsp_data, rsp_eq, rsp_zero, busy);
        end
        edge_commit();
        drive(2'b00, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0, 3'd0, 2'b01);
        edge_commit();
        drive(2'b00, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0, 3'd0, 2'b00);
        compared++;
        if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL single_release: valid=%b busy=%b, required 00/0", rsp_valid, busy);
        end
        edge_commit();
    endtask

    task automatic test_contention();
        logic [31:0] a0, b0, a1, b1, pa, pb;
        logic [2:0]  c0, c1, pc;
        int          exp_g, prev_g;
        reset_dut();
        prev_g = 0; pa = '0; pb = '0; pc = '0;
        for (int k = 0; k < 8; k++) begin
            a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
            c0 = 3'($urandom_range(0, 3)); c1 = 3'($urandom_range(0, 3));
            drive(2'b11, a0, b0, c0, a1, b1, c1, 2'b11);
            exp_g = FIXED ? 0 : (k % 2);
            compared++;
            if (req_ready !== (2'b01 << exp_g)) begin
                mismatched++;
                $display("FAIL contend_grant[%0d]: req_ready=%b, required %b", k, req_ready, 2'b01 << exp_g);
            end
            if (k > 0) begin
                compared++;
                if (rsp_valid !== (2'b01 << prev_g) || rsp_data !== ref_alu(pa, pb, pc)) begin
                    mismatched++;
                    $display("FAIL contend_rsp[%0d]: valid=%b data=%h, required %b/%h", k, rsp_valid,
                             rsp_data, 2'b01 << prev_g, ref_alu(pa, pb, pc));
                end
            end
            prev_g = exp_g;
            pa = exp_g ? a1 : a0; pb = exp_g ? b1 : b0; pc = exp_g ? c1 : c0;
            edge_commit();
        end
        drive(2'b00, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0, 3'd0, 2'b11);
        edge_commit();
    endtask

    task automatic test_backpressure();
        reset_dut();
        drive(2'b10, 32'd0, 32'd0, 3'd0, 32'd9, 32'd9, 3'd1, 2'b00);
        compared++;
        if (req_ready !== 2'b10) begin
            mismatched++;
            $display("FAIL bp_accept: req_ready=%b, required 10", req_ready);
        end
        edge_commit();
        for (int i = 0; i < 3; i++) begin
            drive(2'b01, 32'd3, 32'd4, 3'd0, 32'd9, 32'd9, 3'd1, (i == 1) ? 2'b01 : 2'b00);
            compared++;
            if (rsp_valid !== 2'b10 || rsp_data !== 32'd0 || rsp_zero !== 1'b1 ||
                rsp_eq !== 1'b1 || req_ready !== 2'b00) begin
                mismatched++;
                $display("FAIL bp_hold[%0d]: valid=%b data=%h zero=%b eq=%b ready=%b, required 10/0/1/1/00",
                         i, rsp_valid, rsp_data, rsp_zero, rsp_eq, req_ready);
            end
            edge_commit();
        end
        drive(2'b01, 32'd3, 32'd4, 3'd0, 32'd9, 32'd9, 3'd1, 2'b10);
        compared++;
        if (rsp_valid !== 2'b10 || req_ready !== 2'b01) begin
            mismatched++;
            $display("FAIL bp_release: valid=%b ready=%b, required 10/01", rsp_valid, req_ready);
        end
        edge_commit();
        drive(2'b00, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0, 3'd0, 2'b01);
        compared++;
        if (rsp_valid !== 2'b01 || rsp_data !== 32'd7) begin
            mismatched++;
            $display("FAIL bp_next: valid=%b data=%h, required 01/7", rsp_valid, rsp_data);
        end
        edge_commit();
    endtask

    typedef struct {
        logic [31:0] a, b;
        logic [2:0]  c;
        logic [31:0] d;
        logic        eq, zero;
    } code_vec_t;

    task automatic test_codes();
        code_vec_t tv[4];
        tv[0] = '{32'hFFFF_FFFF, 32'd1, 3'd5, 32'd0, 1'b0, 1'b1};
        tv[1] = '{32'd1,         32'd2, 3'd5, 32'd1, 1'b0, 1'b0};
        tv[2] = '{32'd3,         32'd3, 3'd6, 32'd0, 1'b1, 1'b1};
        tv[3] = '{32'hFFFF_FFFF, 32'd1, 3'd0, 32'd0, 1'b0, 1'b1};
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            drive(2'b01, tv[i].a, tv[i].b, tv[i].c, 32'd0, 32'd0, 3'd0, 2'b00);
            edge_commit();
            drive(2'b00, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0, 3'd0, 2'b01);
            compared++;
            if (rsp_valid !== 2'b01 || rsp_data !== tv[i].d || rsp_eq !== tv[i].eq ||
                rsp_zero !== tv[i].zero) begin
                mismatched++;
                $display("FAIL code[%0d]: valid=%b data=%h eq=%b zero=%b, required 01/%h/%b/%b", i,
                         rsp_valid, rsp_data, rsp_eq, rsp_zero, tv[i].d, tv[i].eq, tv[i].zero);
            end
            edge_commit();
        end
    endtask

    task automatic test_reset_mid_op();
        reset_dut();
        drive(2'b11, 32'd1, 32'd1, 3'd0, 32'd2, 32'd2, 3'd0, 2'b00);
        edge_commit();
        drive(2'b11, 32'd1, 32'd1, 3'd0, 32'd2, 32'd2, 3'd0, 2'b00);
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL midrst_busy: busy=%b, required 1", busy);
        end
        rst_n = 0;
        #1;
        compared++;
        if (rsp_valid !== 2'b00 || busy !== 1'b0 || req_ready !== 2'b00) begin
            mismatched++;
            $display("FAIL midrst_clear: valid=%b busy=%b ready=%b, required 00/0/00", rsp_valid, busy, req_ready);
        end
        model_reset();
        req_valid = '0;
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 2; i++) begin
            drive(2'b00, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0, 3'd0, 2'b11);
            compared++;
            if (rsp_valid !== 2'b00) begin
                mismatched++;
                $display("FAIL midrst_ghost[%0d]: valid=%b, required 00", i, rsp_valid);
            end
            edge_commit();
        end
        drive(2'b11, 32'd4, 32'd5, 3'd0, 32'd6, 32'd7, 3'd0, 2'b11);
        compared++;
        if (req_ready !== 2'b01) begin
            mismatched++;
            $display("FAIL midrst_grant: req_ready=%b, required 01", req_ready);
        end
        edge_commit();
        drive(2'b00, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0, 3'd0, 2'b11);
        edge_commit();
    endtask

    task automatic test_random();
        bit          pend[2];
        logic [31:0] ra[2], rb[2];
        logic [2:0]  rc[2];
        int          acc;
        reset_dut();
        pend[0] = 0; pend[1] = 0;
        for (int n = 0; n < 400; n++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && ($urandom_range(0, 2) != 0)) begin
                    pend[r] = 1;
                    ra[r] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
                    rb[r] = ($urandom_range(0, 3) == 0) ? ra[r] : $urandom;
                    rc[r] = 3'($urandom_range(0, 7));
                end
            end
            drive({pend[1], pend[0]}, ra[0], rb[0], rc[0], ra[1], rb[1], rc[1],
                  2'($urandom_range(0, 3)));
            compared++;
            if (req_ready !== e_ready || rsp_valid !== e_rvalid || busy !== m_held) begin
                mismatched++;
                $display("FAIL rand_ctrl[%0d]: ready=%b valid=%b busy=%b, required %b/%b/%b", n,
                         req_ready, rsp_valid, busy, e_ready, e_rvalid, m_held);
            end
            compared++;
            if (m_held) begin
                if (rsp_data !== e_data || rsp_eq !== e_eq || rsp_zero !== e_zero) begin
                    mismatched++;
                    $display("FAIL rand_data[%0d]: data=%h eq=%b zero=%b, required %h/%b/%b", n,
                             rsp_data, rsp_eq, rsp_zero, e_data, e_eq, e_zero);
                end
            end else if ($isunknown({rsp_data, rsp_eq, rsp_zero})) begin
                mismatched++;
                $display("FAIL rand_known[%0d]: data=%h eq=%b zero=%b, required no X", n,
                         rsp_data, rsp_eq, rsp_zero);
            end
            acc = (e_ready != 2'b00) ? e_winner : -1;
            edge_commit();
            if (acc >= 0) pend[acc] = 0;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_op();
        test_contention();
        test_backpressure();
        test_codes();
        test_reset_mid_op();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
